// File: rtl/dct_pkg.sv
// dct_pkg: constants and types shared by the DCT front end and core
package dct_pkg;
   localparam int DCT_N              = 8;
   localparam int DCT_ELEMS          = DCT_N * DCT_N;
   localparam int DCT_FRAC_BITS      = 16;
   localparam int DCT_DATA_WIDTH     = 32;
   localparam int LEVEL_SHIFT_OFFSET = 128;
   typedef logic signed [DCT_DATA_WIDTH-1:0] dct_elem_t;
   typedef logic [5:0] blk_idx_t;
endpackage

// File: rtl/dct_loader_bank.sv
// dct_loader_bank: 64-entry element bank with indexed write, flat read port and full flag
module dct_loader_bank
   import dct_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    we_i,
   input  logic [5:0]              idx_i,
   input  logic [DW-1:0]           wdata_i,
   input  logic                    set_full_i,
   input  logic                    clr_full_i,
   output logic                    full_o,
   output logic [DW*DCT_ELEMS-1:0] rdata_o
);
   logic [DW-1:0] mem_q [DCT_ELEMS];
   logic full_q, full_d;
   always_ff @(posedge clk) if (we_i) mem_q[idx_i] <= wdata_i;
   always_comb full_d = set_full_i ? 1'b1 : clr_full_i ? 1'b0 : full_q;
   always_ff @(posedge clk) full_q <= reset ? 1'b0 : full_d;
   assign full_o = full_q;
   for (genvar g = 0; g < DCT_ELEMS; g++) begin : g_rd
      assign rdata_o[g*DW +: DW] = mem_q[g];
   end
endmodule

// File: rtl/dct_block_loader.sv
// dct_block_loader: ping-pong 8x8 pixel block assembler feeding dct_2d_8x8
// DCT_LOADER_LEVEL_SHIFT_EN selects signed JPEG level shift (pix-128) instead of plain 0..255.
module dct_block_loader
   import dct_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = DCT_N,
   parameter int FRAC_BITS  = DCT_FRAC_BITS
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [7:0]                             pix_in,
   input  logic                                   pix_valid,
   output logic                                   pix_ready,
   output logic                                   mat_valid,
   input  logic                                   mat_ready,
   output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_out_matrix,
   output logic [15:0]                            blocks_done
);
   function automatic logic [DATA_WIDTH-1:0] to_elem(input logic [7:0] p);
      logic [8:0] s;
`ifdef DCT_LOADER_LEVEL_SHIFT_EN
      s = {1'b0, p} - 9'(LEVEL_SHIFT_OFFSET);
      return {{(DATA_WIDTH-9){s[8]}}, s} << FRAC_BITS;
`else
      s = {1'b0, p};
      return {{(DATA_WIDTH-9){1'b0}}, s} << FRAC_BITS;
`endif
   endfunction
   logic                              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   blk_idx_t                          wr_idx_q, wr_idx_d;
   logic [15:0]                       done_q, done_d;
   logic [1:0]                        full;
   logic                              accept, last, handoff;
   logic [DATA_WIDTH-1:0]             elem;
   logic [DATA_WIDTH*DCT_ELEMS-1:0]   rdata [2];
   assign pix_ready       = !full[wr_bank_q];
   assign mat_valid       = full[rd_bank_q];
   assign accept          = pix_valid && pix_ready;
   assign last            = accept && wr_idx_q == 6'(DCT_ELEMS - 1);
   assign handoff         = mat_valid && mat_ready;
   assign elem            = to_elem(pix_in);
   assign data_out_matrix = rdata[rd_bank_q];
   assign blocks_done     = done_q;
   always_comb begin
      wr_idx_d  = accept ? wr_idx_q + 6'd1 : wr_idx_q;
      wr_bank_d = last ? ~wr_bank_q : wr_bank_q;
      rd_bank_d = handoff ? ~rd_bank_q : rd_bank_q;
      done_d    = done_q + 16'(handoff);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         done_q    <= '0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         done_q    <= done_d;
      end
   end
   // A bank is only written while not full and only cleared while full, so set/clear never collide
   for (genvar b = 0; b < 2; b++) begin : g_bank
      dct_loader_bank #(.DW(DATA_WIDTH)) u_bank (
         .clk        (clk),
         .reset      (reset),
         .we_i       (accept && wr_bank_q == 1'(b)),
         .idx_i      (wr_idx_q),
         .wdata_i    (elem),
         .set_full_i (last && wr_bank_q == 1'(b)),
         .clr_full_i (handoff && rd_bank_q == 1'(b)),
         .full_o     (full[b]),
         .rdata_o    (rdata[b])
      );
   end
endmodule

// File: tb/tb_dct_block_loader.sv
// tb_dct_block_loader: directed and random checks of dct_block_loader against a block-queue model
module tb_dct_block_loader;
   localparam int W = 32;
   localparam int N = 64;
`ifdef DCT_LOADER_LEVEL_SHIFT_EN
   localparam logic [31:0] E_K0 = 32'hFF80_0000;
   localparam logic [31:0] E_K63 = 32'hFFBF_0000;
   localparam logic [31:0] E_FF = 32'h007F_0000;
   localparam logic [31:0] E_80 = 32'h0000_0000;
`else
   localparam logic [31:0] E_K0 = 32'h0000_0000;
   localparam logic [31:0] E_K63 = 32'h003F_0000;
   localparam logic [31:0] E_FF = 32'h00FF_0000;
   localparam logic [31:0] E_80 = 32'h0080_0000;
`endif
   logic clk = 1'b0;
   logic reset, pix_valid, pix_ready, mat_valid, mat_ready;
   logic [7:0] pix_in;
   logic [W*N-1:0] dout;
   logic [15:0] blocks_done;
   int checks = 0;
   int errors = 0;
   logic [W*N-1:0] q[$];
   logic [W*N-1:0] cur;
   int cnt;
   logic [15:0] m_done;
   always #5 clk = ~clk;
   dct_block_loader dut (
      .clk             (clk),
      .reset           (reset),
      .pix_in          (pix_in),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .mat_valid       (mat_valid),
      .mat_ready       (mat_ready),
      .data_out_matrix (dout),
      .blocks_done     (blocks_done)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] conv(input logic [7:0] p);
`ifdef DCT_LOADER_LEVEL_SHIFT_EN
      return (32'(p) - 32'd128) << 16;
`else
      return 32'(p) << 16;
`endif
   endfunction
   task automatic do_reset();
      reset = 1'b1;
      pix_valid = 1'b0;
      mat_ready = 1'b0;
      pix_in = 8'h00;
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.delete();
      cnt = 0;
      m_done = 16'd0;
   endtask
   // One clock: drive, compare handshake/state/data against the model, then advance the model
   task automatic cycle(input logic v, input logic [7:0] p, input logic mr, output logic acc);
      logic er, ev, ho;
      logic [W*N-1:0] front;
      pix_valid = v;
      pix_in = p;
      mat_ready = mr;
      er = q.size() < 2;
      ev = q.size() > 0;
      check("pix_ready", 32'(pix_ready), 32'(er));
      check("mat_valid", 32'(mat_valid), 32'(ev));
      check("blocks_done", 32'(blocks_done), 32'(m_done));
      if (ev) begin
         front = q[0];
         for (int i = 0; i < N; i++) check("elem", dout[i*W +: W], front[i*W +: W]);
      end
      acc = v && er;
      ho = ev && mr;
      @(posedge clk);
      #1;
      if (ho) begin
         void'(q.pop_front());
         m_done++;
      end
      if (acc) begin
         cur[cnt*W +: W] = conv(p);
         cnt++;
         if (cnt == N) begin
            q.push_back(cur);
            cnt = 0;
         end
      end
   endtask
   initial begin
      logic acc;
      int n, pulses;
      do_reset();
      check("rst_pix_ready", 32'(pix_ready), 32'd1);
      check("rst_mat_valid", 32'(mat_valid), 32'd0);
      check("rst_blocks_done", 32'(blocks_done), 32'd0);
      // 1: ramp block with downstream always ready
      for (int k = 0; k < N; k++) cycle(1'b1, 8'(k), 1'b1, acc);
      check("t1_valid", 32'(mat_valid), 32'd1);
      check("t1_elem0", dout[0 +: W], E_K0);
      check("t1_elem63", dout[63*W +: W], E_K63);
      cycle(1'b0, 8'h00, 1'b1, acc);
      check("t1_done", 32'(blocks_done), 32'd1);
      check("t1_valid_low", 32'(mat_valid), 32'd0);
      // 2: downstream stalled, both banks fill
      do_reset();
      n = 0;
      for (int c = 0; c < 300 && n < 128; c++) begin
         cycle(1'b1, 8'(n + 3), 1'b0, acc);
         if (acc) n++;
      end
      check("t2_accepts", 32'(n), 32'd128);
      for (int c = 0; c < 3; c++) begin
         check("t2_ready_low", 32'(pix_ready), 32'd0);
         cycle(1'b1, 8'hA5, 1'b0, acc);
      end
      cycle(1'b1, 8'hA5, 1'b1, acc);
      check("t2_ready_back", 32'(pix_ready), 32'd1);
      check("t2_done", 32'(blocks_done), 32'd1);
      cycle(1'b1, 8'hA5, 1'b0, acc);
      for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 1'b1, acc);
      check("t2_drained", 32'(mat_valid), 32'd0);
      // 3: zero-bubble streaming of four blocks
      do_reset();
      pulses = 0;
      for (int i = 0; i < 4 * N; i++) begin
         check("t3_ready", 32'(pix_ready), 32'd1);
         if (mat_valid) pulses++;
         cycle(1'b1, 8'($urandom), 1'b1, acc);
      end
      if (mat_valid) pulses++;
      cycle(1'b0, 8'h00, 1'b1, acc);
      check("t3_pulses", 32'(pulses), 32'd4);
      check("t3_done", 32'(blocks_done), 32'd4);
      // 4: reset mid-block discards partial data
      do_reset();
      for (int i = 0; i < 30; i++) cycle(1'b1, 8'($urandom), 1'b0, acc);
      do_reset();
      for (int i = 0; i < N; i++) cycle(1'b1, 8'hFF, 1'b0, acc);
      for (int i = 0; i < N; i++) check("t4_elem", dout[i*W +: W], E_FF);
      cycle(1'b0, 8'h00, 1'b1, acc);
      check("t4_done", 32'(blocks_done), 32'd1);
      // 5: random gaps on both sides
      do_reset();
      for (int c = 0; c < 60000 && m_done < 16'd100; c++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), acc);
      check("t5_done", 32'(blocks_done), 32'd100);
      // 6: mid-grey block
      do_reset();
      for (int i = 0; i < N; i++) cycle(1'b1, 8'h80, 1'b0, acc);
      for (int i = 0; i < N; i++) check("t6_elem", dout[i*W +: W], E_80);
      cycle(1'b0, 8'h00, 1'b1, acc);
      check("t6_done", 32'(blocks_done), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
